mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single external memory bus (cs/oe/we/addr/data) between the CPU control FSM and the DMA engine.
//  Arbitrates per access, runs a fixed two-phase access sequence, and inserts bus turnaround on owner change.
//  Sits between control/dma and the memory; neither requester drives mem_* directly.
// PARAMETERS
//  ADDR_W      16  address width
//  DATA_W      8   data width
//  TURNAROUND  1   idle cycles inserted when bus owner changes (0 = none)
//  DMA_MAX_BRST 4  max consecutive DMA accesses before a pending CPU request must win (>=1)
// PORTS
//  clk        in   1       system clock, all state on posedge
//  rst        in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU access request; hold with cpu_we/addr/wdata stable until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU access address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle pulse: access done, rdata valid for reads
//  dma_req/dma_we/dma_addr/dma_wdata/dma_ack   same as cpu_* for the DMA requester
//  rdata      out  DATA_W  registered read data, shared by both requesters, valid in ack cycle
//  owner      out  1       0 = CPU, 1 = DMA; last/current bus owner
//  mem_cs     out  1       memory chip select
//  mem_oe     out  1       memory output enable (reads)
//  mem_we     out  1       memory write strobe
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid during ACC_B
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; all mem_* = 0; cpu_ack=dma_ack=0; rdata=0; owner=0; brst_cnt=0.
//  States: IDLE -> (TURN) -> ACC_A -> ACC_B -> IDLE.
//  IDLE: outputs idle (mem_cs=oe=we=0). Sample reqs at clock edge:
//   - none: stay. Only one: grant it. Both: DMA wins unless brst_cnt==DMA_MAX_BRST, then CPU wins.
//   - grantee != owner and TURNAROUND>0 -> TURN; else -> ACC_A. owner updates on grant edge.
//  TURN: bus idle for exactly TURNAROUND cycles (down-counter), then ACC_A; request choice is frozen.
//  ACC_A: mem_cs=1, mem_addr/wdata from grantee, mem_oe=!we; mem_we=0 (address setup).
//  ACC_B: same as ACC_A plus mem_we=we. At edge leaving ACC_B: rdata<=mem_rdata (reads only; writes leave
//   rdata unchanged), grantee ack<=1 for one cycle, state->IDLE.
//  Latency, idle bus, same owner: req seen at edge n -> ACC_A n+1, ACC_B n+2, ack+rdata in cycle n+3.
//  Add TURNAROUND cycles on owner change. Back-to-back same owner: requester keeps req high with the next
//   address in the ack cycle; IDLE samples it there -> 3 cycles/access sustained.
//  brst_cnt: +1 (saturating at DMA_MAX_BRST) on each DMA grant; cleared on CPU grant or on any IDLE edge
//   with dma_req=0. Guarantees CPU latency <= DMA_MAX_BRST accesses + turnaround.
//  Requester inputs are sampled live during ACC_A/ACC_B (stability is the requester's duty); dropping req
//   mid-access does not abort: access completes and ack still pulses.
//  Never both acks in one cycle; never mem_we and mem_oe together.
//  Reset mid-access: access abandoned, no ack issued, bus released immediately.
// STRUCTURE
//  Shared include bus_defs.vh: state encodings (IDLE/TURN/ACC_A/ACC_B), owner codes OWN_CPU/OWN_DMA.
//  control.v and the DMA engine include it for the owner codes.
//  One sub-module is natural: mem_access_seq (ACC_A/ACC_B strobe generation + rdata capture + ack pulse),
//  fed by a muxed request; the arbiter keeps the grant logic, TURN counter and brst_cnt.
// TESTING
//  1 CPU read alone, idle bus, mem_rdata=8'h3E at 16'h0100 -> cpu_ack 3 cycles after req, rdata=8'h3E,
//    no TURN.
//  2 CPU write 8'hA5 to 16'hC000 -> mem_we high only in ACC_B, mem_oe never high, rdata unchanged.
//  3 DMA then CPU back-to-back, TURNAROUND=1 -> one idle cycle between DMA ack and CPU ACC_A, owner 1->0.
//  4 Both req continuously, DMA_MAX_BRST=4 -> grant sequence DMA x4, CPU, DMA x4, CPU... no starvation.
//  5 rst low during ACC_B -> all mem_* and acks 0 same cycle, state IDLE; next access runs normally.
//  6 CPU drops req during ACC_A -> access completes, single cpu_ack pulse, no second access.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: sequencer states and owner codes.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    ACC_A,
    ACC_B
  } bus_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_seq.sv
// Two-phase access strobes for the granted requester, read-data capture and ack pulse.
module mem_access_seq
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  bus_state_t        state,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_ack,
  output logic              dma_ack
);

  logic active;

  // Strobes decode straight from state so a reset releases the bus at once.
  always_comb begin
    active    = (state == ACC_A) || (state == ACC_B);
    mem_cs    = active;
    mem_oe    = active && !we;
    mem_we    = (state == ACC_B) && we;
    mem_addr  = active ? addr : '0;
    mem_wdata = active ? wdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      rdata   <= '0;
    end else begin
      cpu_ack <= (state == ACC_B) && (sel == OWN_CPU);
      dma_ack <= (state == ACC_B) && (sel == OWN_DMA);
      if ((state == ACC_B) && !we) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between CPU and DMA: grant, turnaround and DMA burst limit.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned TURNAROUND   = 1,
  parameter int unsigned DMA_MAX_BRST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned TURN_W    = cnt_width(TURNAROUND);
  localparam int unsigned BRST_W    = cnt_width(DMA_MAX_BRST);
  localparam int unsigned TURN_LOAD = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
  localparam logic [BRST_W-1:0] BRST_MAX = BRST_W'(DMA_MAX_BRST);

  bus_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [BRST_W-1:0] brst_cnt_q, brst_cnt_d;
  logic              grant_dma;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      turn_cnt_q <= '0;
      brst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      turn_cnt_q <= turn_cnt_d;
      brst_cnt_q <= brst_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    turn_cnt_d = turn_cnt_q;
    brst_cnt_d = brst_cnt_q;
    grant_dma  = dma_req && !(cpu_req && (brst_cnt_q == BRST_MAX));
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d = grant_dma ? OWN_DMA : OWN_CPU;
          // A DMA grant at the limit only happens with no CPU request, so it just saturates.
          if (grant_dma) begin
            brst_cnt_d = (brst_cnt_q == BRST_MAX) ? brst_cnt_q : brst_cnt_q + 1'b1;
          end else begin
            brst_cnt_d = '0;
          end
          if ((owner_d != owner_q) && (TURNAROUND > 0)) begin
            state_d    = TURN;
            turn_cnt_d = TURN_W'(TURN_LOAD);
          end else begin
            state_d = ACC_A;
          end
        end else begin
          brst_cnt_d = '0;
        end
      end
      TURN: begin
        if (turn_cnt_q == '0) begin
          state_d = ACC_A;
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      ACC_A:   state_d = ACC_B;
      ACC_B:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign owner = owner_q;

  mem_access_seq #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .state    (state_q),
    .sel      (owner_q),
    .we       ((owner_q == OWN_DMA) ? dma_we : cpu_we),
    .addr     ((owner_q == OWN_DMA) ? dma_addr : cpu_addr),
    .wdata    ((owner_q == OWN_DMA) ? dma_wdata : cpu_wdata),
    .mem_rdata(mem_rdata),
    .mem_cs   (mem_cs),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .rdata    (rdata),
    .cpu_ack  (cpu_ack),
    .dma_ack  (dma_ack)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized two-requester traffic.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned TURNAROUND   = 1;
  localparam int unsigned DMA_MAX_BRST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  rdata;
  logic        owner;
  logic        mem_cs, mem_oe, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem_arr [65536];
  logic [7:0]  ref_mem [65536];
  logic [7:0]  model_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_addr];

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TURNAROUND(TURNAROUND),
    .DMA_MAX_BRST(DMA_MAX_BRST)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .owner(owner),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Advance to the next falling edge; the memory model latches writes strobed in this cycle.
  task automatic tick();
    @(negedge clk);
    if (mem_we) mem_arr[mem_addr] = mem_wdata;
    checks++;
    if (mem_we && mem_oe) begin
      errors++;
      $display("FAIL we_oe_overlap: mem_we=%b mem_oe=%b required not both 1", mem_we, mem_oe);
    end
    checks++;
    if (cpu_ack && dma_ack) begin
      errors++;
      $display("FAIL dual_ack: cpu_ack=%b dma_ack=%b required not both 1", cpu_ack, dma_ack);
    end
  endtask

  task automatic wait_ack(input bit dma, input int limit, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      tick();
      cycles++;
      if (dma ? dma_ack : cpu_ack) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    for (int a = 0; a < 65536; a++) begin
      mem_arr[a] = 8'(a[7:0] ^ a[15:8] ^ 8'h5A);
      ref_mem[a] = mem_arr[a];
    end
    mem_arr[16'h0100] = 8'h3E;
    ref_mem[16'h0100] = 8'h3E;
    #1 rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({mem_cs, mem_oe, mem_we} !== 3'b000 || mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_bus: cs/oe/we=%b%b%b addr=%h wdata=%h required all 0",
               mem_cs, mem_oe, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({cpu_ack, dma_ack, owner} !== 3'b000 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: acks=%b%b owner=%b rdata=%h required 0", cpu_ack, dma_ack, owner, rdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    int cyc;
    bit ok;
    cpu_we = 0; cpu_addr = 16'h0100; cpu_req = 1;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0100 || mem_oe !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_acc_a: cs=%b oe=%b we=%b addr=%h required 1/1/0/0100 with no turnaround",
               mem_cs, mem_oe, mem_we, mem_addr);
    end
    wait_ack(0, 10, cyc, ok);
    cpu_req = 0;
    checks++;
    if (!ok || cyc + 1 != 3) begin
      errors++;
      $display("FAIL cpu_rd_latency: ack_seen=%b cycles=%0d required ack at 3", ok, cyc + 1);
    end
    checks++;
    if (rdata !== 8'h3E || owner !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_data: rdata=%h owner=%b required 3e/0", rdata, owner);
    end
    model_rdata = 8'h3E;
  endtask

  task automatic test_cpu_write();
    int n, we_cycles, we_at;
    bit oe_seen, got;
    cpu_we = 1; cpu_addr = 16'hC000; cpu_wdata = 8'hA5; cpu_req = 1;
    n = 0; we_cycles = 0; we_at = 0; oe_seen = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      n++;
      if (mem_oe) oe_seen = 1;
      if (mem_we) begin we_cycles++; we_at = n; end
      if (cpu_ack) got = 1;
    end
    cpu_req = 0; cpu_we = 0;
    checks++;
    if (!got || n != 3 || we_cycles != 1 || we_at != 2 || oe_seen) begin
      errors++;
      $display("FAIL cpu_wr_strobes: ack=%b at %0d we_cycles=%0d we_at=%0d oe_seen=%b required 1/3/1/2/0",
               got, n, we_cycles, we_at, oe_seen);
    end
    checks++;
    if (mem_arr[16'hC000] !== 8'hA5 || rdata !== model_rdata) begin
      errors++;
      $display("FAIL cpu_wr_data: mem=%h rdata=%h required a5/%h", mem_arr[16'hC000], rdata, model_rdata);
    end
    ref_mem[16'hC000] = 8'hA5;
  endtask

  task automatic test_back_to_back_owner_change();
    int cyc, idle;
    bit ok, found;
    dma_we = 0; dma_addr = 16'h0042; dma_req = 1;
    wait_ack(1, 12, cyc, ok);
    checks++;
    if (!ok || cyc != 3 + TURNAROUND || owner !== 1'b1 || rdata !== ref_mem[16'h0042]) begin
      errors++;
      $display("FAIL dma_rd: ack=%b cycles=%0d owner=%b rdata=%h required 1/%0d/1/%h",
               ok, cyc, owner, rdata, 3 + TURNAROUND, ref_mem[16'h0042]);
    end
    dma_req = 0;
    cpu_we = 0; cpu_addr = 16'hC000; cpu_req = 1;
    idle = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (mem_cs) found = 1; else idle++;
    end
    checks++;
    if (!found || idle != TURNAROUND || owner !== 1'b0) begin
      errors++;
      $display("FAIL turn_gap: found=%b idle=%0d owner=%b required 1/%0d/0", found, idle, owner, TURNAROUND);
    end
    wait_ack(0, 10, cyc, ok);
    cpu_req = 0;
    checks++;
    if (!ok || rdata !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_after_dma: ack=%b rdata=%h required 1/a5", ok, rdata);
    end
    model_rdata = rdata;
    tick();
  endtask

  task automatic test_fairness();
    int streak, n, exp_gap;
    bit model_owner, exp_dma, got;
    cpu_we = 0; cpu_addr = 16'h0100; cpu_req = 1;
    dma_we = 0; dma_addr = 16'h0042; dma_req = 1;
    streak = 0; model_owner = 0;
    for (int g = 0; g < 10; g++) begin
      exp_dma = (streak != DMA_MAX_BRST);
      exp_gap = 3 + ((exp_dma != model_owner) ? TURNAROUND : 0);
      n = 0; got = 0;
      while (!got && n < 20) begin
        tick();
        n++;
        got = cpu_ack | dma_ack;
      end
      checks++;
      if (!got || dma_ack !== exp_dma || n != exp_gap) begin
        errors++;
        $display("FAIL fair_grant%0d: ack=%b dma_ack=%b gap=%0d required 1/%b/%0d",
                 g, got, dma_ack, n, exp_dma, exp_gap);
      end
      streak = exp_dma ? streak + 1 : 0;
      model_owner = exp_dma;
    end
    cpu_req = 0; dma_req = 0;
    model_rdata = 8'h3E;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    bit ok, stray;
    logic [7:0] d;
    cpu_we = 0; cpu_addr = 16'h0100; cpu_req = 1;
    tick();
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: cs=%b oe=%b required 1/1 in access", mem_cs, mem_oe);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_cs, mem_oe, mem_we, cpu_ack, dma_ack, owner} !== 6'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_release: cs/oe/we=%b%b%b acks=%b%b owner=%b rdata=%h required 0",
               mem_cs, mem_oe, mem_we, cpu_ack, dma_ack, owner, rdata);
    end
    cpu_req = 0;
    stray = 0;
    tick();
    if (cpu_ack) stray = 1;
    rst = 1'b1;
    tick();
    if (cpu_ack) stray = 1;
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rst_mid_ack: stray cpu_ack=1 required 0");
    end
    d = 8'($urandom);
    dma_we = 1; dma_addr = 16'h0300; dma_wdata = d; dma_req = 1;
    wait_ack(1, 12, cyc, ok);
    dma_req = 0; dma_we = 0;
    checks++;
    if (!ok || cyc != 3 + TURNAROUND || rdata !== 8'h00) begin
      errors++;
      $display("FAIL post_rst_dma_wr: ack=%b cycles=%0d rdata=%h required 1/%0d/00", ok, cyc, rdata, 3 + TURNAROUND);
    end
    ref_mem[16'h0300] = d;
    cpu_we = 0; cpu_addr = 16'h0300; cpu_req = 1;
    wait_ack(0, 12, cyc, ok);
    cpu_req = 0;
    checks++;
    if (!ok || cyc != 3 + TURNAROUND || rdata !== d) begin
      errors++;
      $display("FAIL post_rst_cpu_rd: ack=%b cycles=%0d rdata=%h required 1/%0d/%h", ok, cyc, rdata, 3 + TURNAROUND, d);
    end
    model_rdata = d;
  endtask

  task automatic test_drop_req();
    int acks, extra_cs;
    bit started;
    cpu_we = 0; cpu_addr = 16'h0200; cpu_req = 1;
    started = 0;
    for (int i = 0; i < 6 && !started; i++) begin
      tick();
      if (mem_cs) started = 1;
    end
    cpu_req = 0;
    acks = 0; extra_cs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ack) acks++;
      if (acks > 0 && mem_cs) extra_cs++;
    end
    checks++;
    if (!started || acks != 1 || extra_cs != 0 || rdata !== ref_mem[16'h0200]) begin
      errors++;
      $display("FAIL drop_req: started=%b acks=%0d extra_cs=%0d rdata=%h required 1/1/0/%h",
               started, acks, extra_cs, rdata, ref_mem[16'h0200]);
    end
    model_rdata = ref_mem[16'h0200];
  endtask

  task automatic test_random();
    bit cpu_busy, dma_busy, abort;
    int cpu_wait, dma_wait, cpu_done, dma_done;
    cpu_busy = 0; dma_busy = 0; abort = 0;
    cpu_wait = 0; dma_wait = 0; cpu_done = 0; dma_done = 0;
    for (int cyc = 0; cyc < 700 && !abort; cyc++) begin
      tick();
      if (cpu_ack) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else model_rdata = ref_mem[cpu_addr];
        checks++;
        if (!cpu_busy || rdata !== model_rdata) begin
          errors++;
          $display("FAIL rnd_cpu_ack: busy=%b we=%b addr=%h rdata=%h required 1/%h", cpu_busy, cpu_we, cpu_addr, rdata, model_rdata);
        end
        cpu_busy = 0; cpu_req = 0; cpu_done++;
      end
      if (dma_ack) begin
        if (dma_we) ref_mem[dma_addr] = dma_wdata;
        else model_rdata = ref_mem[dma_addr];
        checks++;
        if (!dma_busy || rdata !== model_rdata) begin
          errors++;
          $display("FAIL rnd_dma_ack: busy=%b we=%b addr=%h rdata=%h required 1/%h", dma_busy, dma_we, dma_addr, rdata, model_rdata);
        end
        dma_busy = 0; dma_req = 0; dma_done++;
      end
      if (cpu_busy) cpu_wait++;
      if (dma_busy) dma_wait++;
      if (cpu_wait > 40 || dma_wait > 40) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout: cpu_wait=%0d dma_wait=%0d required <=40", cpu_wait, dma_wait);
        abort = 1;
      end
      if (cyc < 620 && !cpu_busy && $urandom_range(0, 2) != 0) begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 16'h2000 + 16'($urandom_range(0, 7));
        cpu_wdata = 8'($urandom); cpu_req = 1; cpu_busy = 1; cpu_wait = 0;
      end
      if (cyc < 620 && !dma_busy && $urandom_range(0, 2) != 0) begin
        dma_we = 1'($urandom_range(0, 1)); dma_addr = 16'h2000 + 16'($urandom_range(0, 7));
        dma_wdata = 8'($urandom); dma_req = 1; dma_busy = 1; dma_wait = 0;
      end
    end
    checks++;
    if (cpu_busy || dma_busy || cpu_done < 20 || dma_done < 20) begin
      errors++;
      $display("FAIL rnd_drain: busy=%b%b done=%0d/%0d required idle and >=20 each", cpu_busy, dma_busy, cpu_done, dma_done);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_back_to_back_owner_change();
    test_fairness();
    test_reset_mid_access();
    test_drop_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
